// File: rtl/exp6_pkg.sv
// Shared definitions for experiment_number_six: FSM state encoding, default sizes
// and the fixed message ROM.
package exp6_pkg;

    localparam int CPB_DEF     = 16;
    localparam int MSG_LEN_DEF = 12;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD   = 4'd1,
        ST_START  = 4'd2,
        ST_DATA   = 4'd3,
        ST_STOP   = 4'd4,
        ST_DONE   = 4'd5,
        ST_PARITY = 4'd6
    } state_t;

    // "HELLO TT04\r\n"; anything past the message reads as 0
    function automatic logic [7:0] char_at(input logic [7:0] idx);
        logic [7:0] c;
        case (idx)
            8'd0:    c = 8'h48;
            8'd1:    c = 8'h45;
            8'd2:    c = 8'h4C;
            8'd3:    c = 8'h4C;
            8'd4:    c = 8'h4F;
            8'd5:    c = 8'h20;
            8'd6:    c = 8'h54;
            8'd7:    c = 8'h54;
            8'd8:    c = 8'h30;
            8'd9:    c = 8'h34;
            8'd10:   c = 8'h0D;
            8'd11:   c = 8'h0A;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/exp6_if.sv
// Signal bundles: exp6_baud_if links the FSM to its bit timer, exp6_if groups the
// Tiny Tapeout user pins as seen by a harness (master) and the block (slave).
interface exp6_baud_if;
    logic clear;
    logic bit_done;

    modport master (output clear, input bit_done);
    modport slave  (input clear, output bit_done);
endinterface

interface exp6_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] chars_remaining;
    logic [3:0] which_state;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe, chars_remaining, which_state
    );
    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe, chars_remaining, which_state
    );
endinterface

// File: rtl/exp6_baud_gen.sv
// Bit timer: counts enabled cycles and pulses bit_done on the last cycle of each
// UART bit; restarts from 0 whenever the FSM changes state.
module exp6_baud_gen
    import exp6_pkg::*;
#(
    parameter int CLKS_PER_BIT = CPB_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      ena,
    exp6_baud_if.slave bif
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last       = (r_cnt == LAST);
    assign bif.bit_done = w_last;

    // Reload on bit end instead of wrapping, so each bit is exactly CLKS_PER_BIT long
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_cnt <= '0;
        end else if (ena) begin
            if (bif.clear || w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/experiment_number_six.sv
// Tiny Tapeout block sending "HELLO TT04\r\n" as UART on uo_out[0] after a start edge.
// Define PARITY_EN to insert an even-parity bit after the data bits.
module experiment_number_six
    import exp6_pkg::*;
#(
    parameter int CLKS_PER_BIT = CPB_DEF,
    parameter int MSG_LEN      = MSG_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] chars_remaining,
    output logic [3:0] which_state
);

    localparam logic [7:0] LEN8 = 8'(MSG_LEN);

    state_t     r_state;
    state_t     w_next;
    logic       r_start_q;
    logic [7:0] r_shift;
    logic [7:0] r_char;
    logic [7:0] r_chars;
    logic [7:0] r_index;
    logic [2:0] r_bit_idx;

    logic w_edge;
    logic w_abort;
    logic w_bit_done;
    logic w_tx;
    logic w_unused_pins;

    assign w_edge        = ui_in[0] & ~r_start_q;
    assign w_abort       = ui_in[1];
    assign w_unused_pins = ^{uio_in, ui_in[7:2]};

    exp6_baud_if u_bif ();

    assign u_bif.clear = (w_next != r_state);
    assign w_bit_done  = u_bif.bit_done;

    exp6_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bif   (u_bif)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
        end else if (ena) begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_edge) w_next = ST_LOAD;
            ST_LOAD:  w_next = ST_START;
            ST_START: if (w_bit_done) w_next = ST_DATA;
            ST_DATA: begin
                if (w_bit_done && (r_bit_idx == 3'd7)) begin
`ifdef PARITY_EN
                    w_next = ST_PARITY;
`else
                    w_next = ST_STOP;
`endif
                end
            end
`ifdef PARITY_EN
            ST_PARITY: if (w_bit_done) w_next = ST_STOP;
`endif
            ST_STOP: begin
                if (w_bit_done) begin
                    w_next = (r_chars == 8'd1) ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        // Abort overrides everything, including a simultaneous start edge
        if (w_abort) begin
            w_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_start_q <= 1'b0;
            r_shift   <= 8'h00;
            r_char    <= 8'h00;
            r_chars   <= 8'h00;
            r_index   <= 8'h00;
            r_bit_idx <= 3'd0;
        end else if (ena) begin
            r_start_q <= ui_in[0];
            if (w_abort) begin
                r_chars <= 8'h00;
                r_char  <= 8'h00;
                r_index <= 8'h00;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_edge) begin
                            r_chars <= LEN8;
                            r_index <= 8'h00;
                        end
                    end
                    ST_LOAD: begin
                        r_shift <= char_at(r_index);
                        r_char  <= char_at(r_index);
                    end
                    ST_START: r_bit_idx <= 3'd0;
                    ST_DATA: begin
                        if (w_bit_done) begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                    ST_STOP: begin
                        if (w_bit_done) begin
                            r_chars <= r_chars - 8'd1;
                            if (r_chars != 8'd1) begin
                                r_index <= r_index + 8'd1;
                            end
                        end
                    end
                    ST_DONE:  r_char <= 8'h00;
                    default:  r_char <= r_char;
                endcase
            end
        end
    end

    always_comb begin
        w_tx = 1'b1;
        case (r_state)
            ST_START:  w_tx = 1'b0;
            ST_DATA:   w_tx = r_shift[0];
`ifdef PARITY_EN
            ST_PARITY: w_tx = ^r_char;
`endif
            default:   w_tx = 1'b1;
        endcase
    end

    assign uo_out          = {5'b00000, (r_state == ST_DONE), (r_state != ST_IDLE), w_tx};
    assign uio_out         = r_char;
    assign uio_oe          = 8'hFF;
    assign chars_remaining = r_chars;
    assign which_state     = r_state;

endmodule

// File: tb/tb_experiment_number_six.sv
// Self-checking bench for experiment_number_six: UART decoder + message reference model.
module tb_experiment_number_six;
  localparam int CPB = 16;
  localparam int MSG_LEN = 12;
`ifdef PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = 1 + NBITS * CPB;
  localparam int MSG_CYC = MSG_LEN * FRAME + 1;
  localparam int LIMIT = 4000;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  exp6_if bus ();

  experiment_number_six dut (
    .clk(clk), .rst_n(rst_n), .ena(bus.ena), .ui_in(bus.ui_in), .uo_out(bus.uo_out),
    .uio_in(bus.uio_in), .uio_out(bus.uio_out), .uio_oe(bus.uio_oe),
    .chars_remaining(bus.chars_remaining), .which_state(bus.which_state)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  string msg_str = "HELLO TT04\r\n";
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic par_q[$];

  // UART receiver: counts only enabled cycles, samples mid-bit
  bit mon_active = 0;
  bit mon_rst = 0;
  int mon_cnt = 0;
  int mon_b = 0;
  int mon_ferr = 0;
  logic [7:0] mon_byte;
  logic mon_par;
  bit saw6 = 0;

  always @(negedge clk) begin
    if (rst_n || mon_rst) begin
      mon_active = 0;
      mon_cnt = 0;
    end else if (bus.ena) begin
      if (bus.which_state == 4'd6) saw6 = 1;
      if (!mon_active) begin
        if (bus.uo_out[0] == 1'b0) begin
          mon_active = 1;
          mon_cnt = 1;
        end
      end else begin
        if (mon_cnt % CPB == CPB / 2) begin
          mon_b = mon_cnt / CPB;
          if (mon_b >= 1 && mon_b <= 8) mon_byte[mon_b-1] = bus.uo_out[0];
          if (NBITS == 11 && mon_b == 9) mon_par = bus.uo_out[0];
          if (mon_b == NBITS - 1) begin
            if (bus.uo_out[0] !== 1'b1) mon_ferr++;
            rx_q.push_back(mon_byte);
            par_q.push_back(mon_par);
            mon_active = 0;
          end
        end
        mon_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
  endtask

  task automatic idle_gap();
    int n;
    n = $urandom_range(1, 20);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Follows a running message until IDLE; optionally stalls ena or pokes start while busy
  task automatic track_msg(input int off0, input int stall_char, input bit poke,
                           output int done_off, output int idle_off, output int n_done,
                           output int hold_err);
    int off;
    bit stalled;
    int extra;
    logic tx_h;
    logic [3:0] st_h;
    off = off0; stalled = 0; done_off = -1; n_done = 0; hold_err = 0;
    while (bus.which_state != 4'd0 && off < LIMIT) begin
      if (bus.uo_out[2]) begin n_done++; done_off = off; end
      if (!stalled && stall_char >= 0 && bus.which_state == 4'd3 &&
          bus.chars_remaining == 8'(MSG_LEN - stall_char)) begin
        stalled = 1;
        extra = $urandom_range(0, 100);
        for (int i = 0; i < extra; i++) begin tick(); off++; end
        bus.ena = 1'b0;
        tx_h = bus.uo_out[0];
        st_h = bus.which_state;
        for (int i = 0; i < 50; i++) begin
          tick(); off++;
          if (bus.uo_out[0] !== tx_h || bus.which_state !== st_h) hold_err++;
        end
        bus.ena = 1'b1;
      end
      if (poke && off == 300) bus.ui_in[0] = 1'b1;
      if (poke && off == 301) bus.ui_in[0] = 1'b0;
      tick();
      off++;
    end
    idle_off = off;
  endtask

  task automatic run_msg(input int stall_char, input bit poke, output int done_off,
                         output int idle_off, output int n_done, output int hold_err);
    rx_q.delete(); par_q.delete(); mon_ferr = 0;
    bus.ui_in[0] = 1'b1;
    tick();
    bus.ui_in[0] = 1'b0;
    track_msg(0, stall_char, poke, done_off, idle_off, n_done, hold_err);
  endtask

  task automatic test_reset();
    bus.ena = 1'b1;
    bus.ui_in = 8'h00;
    bus.uio_in = 8'($urandom_range(0, 255));
    do_reset();
    n_total++; if (bus.which_state !== 4'd0) $display("FAIL reset_state got %0d want 0", bus.which_state); else n_pass++;
    n_total++; if (bus.chars_remaining !== 8'd0) $display("FAIL reset_count got %0d want 0", bus.chars_remaining); else n_pass++;
    n_total++; if (bus.uo_out !== 8'h01) $display("FAIL reset_uo_out got %h want 01", bus.uo_out); else n_pass++;
    n_total++; if (bus.uio_out !== 8'h00) $display("FAIL reset_uio_out got %h want 00", bus.uio_out); else n_pass++;
    n_total++; if (bus.uio_oe !== 8'hFF) $display("FAIL reset_uio_oe got %h want ff", bus.uio_oe); else n_pass++;
  endtask

  task automatic test_message();
    int d_off, i_off, nd, herr;
    logic [7:0] got;
    idle_gap();
    rx_q.delete(); par_q.delete(); mon_ferr = 0; saw6 = 0;
    bus.ui_in[0] = 1'b1;
    tick();
    n_total++; if (bus.which_state !== 4'd1) $display("FAIL msg_load_state got %0d want 1", bus.which_state); else n_pass++;
    bus.ui_in[0] = 1'b0;
    tick();
    n_total++; if (bus.which_state !== 4'd2) $display("FAIL msg_start_state got %0d want 2", bus.which_state); else n_pass++;
    n_total++; if (bus.chars_remaining !== 8'(MSG_LEN)) $display("FAIL msg_count got %0d want %0d", bus.chars_remaining, MSG_LEN); else n_pass++;
    n_total++; if (bus.uio_out !== exp_q[0]) $display("FAIL msg_first_char got %h want %h", bus.uio_out, exp_q[0]); else n_pass++;
    n_total++; if (bus.uo_out[1:0] !== 2'b10) $display("FAIL msg_busy_tx got %b want 10", bus.uo_out[1:0]); else n_pass++;
    track_msg(1, -1, 1'b0, d_off, i_off, nd, herr);
    n_total++; if (nd !== 1) $display("FAIL msg_done_count got %0d want 1", nd); else n_pass++;
    n_total++; if (d_off !== MSG_LEN * FRAME) $display("FAIL msg_done_time got %0d want %0d", d_off, MSG_LEN * FRAME); else n_pass++;
    n_total++; if (i_off !== MSG_CYC) $display("FAIL msg_busy_len got %0d want %0d", i_off, MSG_CYC); else n_pass++;
    n_total++; if (bus.chars_remaining !== 8'd0 || bus.uio_out !== 8'd0) $display("FAIL msg_end_regs got %h/%h want 00/00", bus.chars_remaining, bus.uio_out); else n_pass++;
    n_total++; if (mon_ferr !== 0) $display("FAIL msg_framing got %0d want 0", mon_ferr); else n_pass++;
    for (int i = 0; i < MSG_LEN; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_total++; if (got !== exp_q[i]) $display("FAIL msg_byte%0d got %h want %h", i, got, exp_q[i]); else n_pass++;
    end
`ifdef PARITY_EN
    n_total++; if (saw6 !== 1'b1) $display("FAIL parity_state got %0d want 1", saw6); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      n_total++; if (par_q[i] !== ($countones(exp_q[i]) % 2 == 1)) $display("FAIL parity_bit%0d got %b want %b", i, par_q[i], ($countones(exp_q[i]) % 2 == 1)); else n_pass++;
    end
`endif
  endtask

  task automatic test_abort();
    int off, extra, nd, busy_cyc;
    idle_gap();
    rx_q.delete(); par_q.delete();
    bus.ui_in[0] = 1'b1;
    tick();
    bus.ui_in[0] = 1'b0;
    off = 0;
    while (bus.chars_remaining != 8'(MSG_LEN - 2) && off < LIMIT) begin tick(); off++; end
    n_total++; if (off >= LIMIT) $display("FAIL abort_reach_char3 got timeout want char 3"); else n_pass++;
    extra = $urandom_range(0, (NBITS - 1) * CPB);
    for (int i = 0; i < extra; i++) tick();
    bus.ui_in[1] = 1'b1;
    tick();
    bus.ui_in[1] = 1'b0;
    mon_rst = 1'b1;
    n_total++; if (bus.which_state !== 4'd0) $display("FAIL abort_state got %0d want 0", bus.which_state); else n_pass++;
    n_total++; if (bus.uo_out !== 8'h01) $display("FAIL abort_uo_out got %h want 01", bus.uo_out); else n_pass++;
    n_total++; if (bus.chars_remaining !== 8'd0) $display("FAIL abort_count got %0d want 0", bus.chars_remaining); else n_pass++;
    n_total++; if (bus.uio_out !== 8'd0) $display("FAIL abort_uio_out got %h want 00", bus.uio_out); else n_pass++;
    nd = 0; busy_cyc = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      mon_rst = 1'b0;
      if (bus.uo_out[2]) nd++;
      if (bus.which_state != 4'd0) busy_cyc++;
    end
    n_total++; if (nd !== 0 || busy_cyc !== 0) $display("FAIL abort_quiet got done=%0d busy=%0d want 0/0", nd, busy_cyc); else n_pass++;
    n_total++; if (rx_q.size() !== 2) $display("FAIL abort_rx_len got %0d want 2", rx_q.size()); else n_pass++;
    n_total++; if (rx_q.size() == 2 && (rx_q[0] !== exp_q[0] || rx_q[1] !== exp_q[1])) $display("FAIL abort_rx_bytes got %h%h want %h%h", rx_q[0], rx_q[1], exp_q[0], exp_q[1]); else n_pass++;
  endtask

  task automatic test_ena_stall();
    int d_off, i_off, nd, herr, k;
    logic [7:0] got;
    idle_gap();
    k = $urandom_range(0, MSG_LEN - 1);
    run_msg(k, 1'b0, d_off, i_off, nd, herr);
    n_total++; if (herr !== 0) $display("FAIL stall_hold got %0d changes want 0 (char %0d)", herr, k); else n_pass++;
    n_total++; if (d_off !== MSG_LEN * FRAME + 50) $display("FAIL stall_done_time got %0d want %0d", d_off, MSG_LEN * FRAME + 50); else n_pass++;
    n_total++; if (i_off !== MSG_CYC + 50) $display("FAIL stall_busy_len got %0d want %0d", i_off, MSG_CYC + 50); else n_pass++;
    n_total++; if (nd !== 1) $display("FAIL stall_done_count got %0d want 1", nd); else n_pass++;
    for (int i = 0; i < MSG_LEN; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      n_total++; if (got !== exp_q[i]) $display("FAIL stall_byte%0d got %h want %h", i, got, exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int d_off, i_off, nd, herr, errs;
    idle_gap();
    bus.ui_in[1:0] = 2'b11;
    tick();
    n_total++; if (bus.which_state !== 4'd0 || bus.chars_remaining !== 8'd0) $display("FAIL abort_beats_start got %0d/%0d want 0/0", bus.which_state, bus.chars_remaining); else n_pass++;
    bus.ui_in[1:0] = 2'b00;
    tick();
    for (int m = 0; m < 2; m++) begin
      run_msg(-1, (m == 0), d_off, i_off, nd, herr);
      n_total++; if (i_off !== MSG_CYC || nd !== 1) $display("FAIL b2b%0d_timing got len=%0d done=%0d want %0d/1", m, i_off, nd, MSG_CYC); else n_pass++;
      errs = (rx_q.size() == MSG_LEN) ? 0 : 1;
      for (int i = 0; i < rx_q.size() && i < MSG_LEN; i++) if (rx_q[i] !== exp_q[i]) errs++;
      n_total++; if (errs !== 0) $display("FAIL b2b%0d_bytes got %0d errors want 0", m, errs); else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    int n;
    idle_gap();
    bus.ui_in[0] = 1'b1;
    tick();
    bus.ui_in[0] = 1'b0;
    n = $urandom_range(10, 1500);
    for (int i = 0; i < n; i++) tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    n_total++; if (bus.which_state !== 4'd0) $display("FAIL midrst_state got %0d want 0", bus.which_state); else n_pass++;
    n_total++; if (bus.uo_out !== 8'h01 || bus.uio_out !== 8'h00) $display("FAIL midrst_outs got %h/%h want 01/00", bus.uo_out, bus.uio_out); else n_pass++;
    n_total++; if (bus.chars_remaining !== 8'd0) $display("FAIL midrst_count got %0d want 0", bus.chars_remaining); else n_pass++;
    tick();
  endtask

  initial begin
    for (int i = 0; i < MSG_LEN; i++) exp_q.push_back(msg_str[i]);
    bus.ena = 1'b1;
    bus.ui_in = 8'h00;
    bus.uio_in = 8'h00;
    test_reset();
    test_message();
    test_abort();
    test_ena_stall();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
